// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB requester bridge.
// No logic of its own; imported by the RTL and the bench.
package apb_master_bridge_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  tmo;
    } rsp_t;

    // Counter width able to hold 0..limit
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response stream and APB bus bundles.
// master drives the request side of each bundle, slave answers it.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_tmo;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo
    );
endinterface

interface apb_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge_watchdog.sv
// ACCESS-phase watchdog: counts enabled cycles, o_expired is combinational on the
// TIMEOUT-th enabled cycle; no backpressure, clear has priority over enable.
module apb_watchdog
    import apb_master_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(TIMEOUT - 1));
    assign o_expired  = i_enable && w_at_limit;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/apb_master_bridge.sv
// Command stream to APB SETUP/ACCESS bridge, one transfer outstanding; response 4 cycles
// after accept with a 1-wait slave. cmd_ready only in IDLE; response held until rsp_ready.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic                pclk,
    input  logic                preset,
    apb_master_bridge_if.slave  req,
    apb_bus_if.master           apb
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_capture;
    logic              w_abort;
    logic              w_expired;
    logic              w_in_access;

    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_tmo;

    assign w_in_access   = (r_state == ACCESS);
    assign w_accept      = (r_state == IDLE) && req.cmd_valid;
    assign req.cmd_ready = (r_state == IDLE);

    apb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .pclk      (pclk),
        .preset    (preset),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE:    if (req.cmd_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS: begin
                // A late pready on the final watchdog cycle still completes normally
                if (apb.pready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    if (req.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_psel    <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
            r_penable <= (w_state_nxt == ACCESS);
            if (w_accept) begin
                r_pwrite <= req.cmd_write;
                r_paddr  <= req.cmd_addr;
                r_pwdata <= req.cmd_wdata;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_rsp_valid <= (w_state_nxt == RESP);
            if (w_capture) begin
                r_rsp_rdata <= (!r_pwrite && !apb.pslverr) ? apb.prdata : '0;
                r_rsp_err   <= apb.pslverr;
                r_rsp_tmo   <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
                r_rsp_tmo   <= 1'b1;
            end
        end
    end

    assign apb.psel      = r_psel;
    assign apb.penable   = r_penable;
    assign apb.pwrite    = r_pwrite;
    assign apb.paddr     = r_paddr;
    assign apb.pwdata    = r_pwdata;
    assign req.rsp_valid = r_rsp_valid;
    assign req.rsp_rdata = r_rsp_rdata;
    assign req.rsp_err   = r_rsp_err;
    assign req.rsp_tmo   = r_rsp_tmo;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge with a 32-word APB RAM model (one wait state, pslverr
// above word 31, optional never-ready stub mode) and a response scoreboard.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) req ();
    apb_bus_if           #(.ADDR_W(32), .DATA_W(32)) apb ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk   (pclk),
        .preset (preset),
        .req    (req),
        .apb    (apb)
    );

    int   total = 0;
    int   bad   = 0;
    rsp_t sb[$];

    // APB RAM model
    logic [31:0] mem [32];
    logic        stub = 1'b0;
    int          acc;

    assign apb.pready  = apb.psel && apb.penable && !stub && (acc == 1);
    assign apb.pslverr = apb.pready && (apb.paddr >= 32);
    assign apb.prdata  = (apb.paddr < 32) ? mem[apb.paddr[4:0]] : 32'hBAD0BAD0;

    always @(posedge pclk or posedge preset) begin
        if (preset) acc <= 0;
        else if (apb.psel && apb.penable && !apb.pready) acc <= acc + 1;
        else acc <= 0;
    end

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (apb.pready && apb.pwrite && apb.paddr < 32) begin
            mem[apb.paddr[4:0]] <= apb.pwdata;
        end
    end

    // Protocol monitor
    logic        p_psel = 1'b0, p_pen = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;

    always @(posedge pclk) begin
        if (preset) begin
            p_psel = 1'b0;
            p_pen  = 1'b0;
            p_rdy  = 1'b0;
        end else begin
            if (apb.psel) begin
                total++;
                if (apb.penable && !p_psel) begin
                    bad++;
                    $display("FAIL proto_setup: penable=1 with prev psel=%b (required prev psel=1)", p_psel);
                end else if (p_psel && !(p_pen && p_rdy) &&
                             ({apb.paddr, apb.pwrite, apb.pwdata} !== {p_addr, p_wr, p_wdata})) begin
                    bad++;
                    $display("FAIL proto_stable: addr=%h wr=%b wdata=%h required addr=%h wr=%b wdata=%h",
                             apb.paddr, apb.pwrite, apb.pwdata, p_addr, p_wr, p_wdata);
                end
            end else if (apb.penable) begin
                total++;
                bad++;
                $display("FAIL proto_penable: penable=1 psel=0 (required psel=1)");
            end
            p_psel  = apb.psel;
            p_pen   = apb.penable;
            p_rdy   = apb.pready;
            p_addr  = apb.paddr;
            p_wr    = apb.pwrite;
            p_wdata = apb.pwdata;
        end
    end

    task automatic issue(input cmd_t c, output bit ok);
        req.cmd_write = c.write;
        req.cmd_addr  = c.addr;
        req.cmd_wdata = c.wdata;
        req.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (req.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge pclk); #1;
        end
        @(posedge pclk); #1;
        req.cmd_valid = 1'b0;
    endtask

    task automatic collect(input bit keep, output rsp_t got, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 60; n++) begin
            if (req.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge pclk); #1;
            lat++;
        end
        got.rdata = req.rsp_rdata;
        got.err   = req.rsp_err;
        got.tmo   = req.rsp_tmo;
        req.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        req.rsp_ready = keep;
    endtask

    task automatic test_reset();
        logic [110:0] obs;
        #12;
        obs = {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata,
               req.rsp_valid, req.rsp_rdata, req.rsp_err, req.rsp_tmo, req.cmd_ready};
        total++;
        if (obs !== {110'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got %h required %h", obs, {110'b0, 1'b1});
        end
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_write_read();
        rsp_t got, exp;
        bit   ok_c, ok_r;
        int   lat;
        sb.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        issue('{write: 1'b1, addr: 32'd5, wdata: 32'hDEADBEEF}, ok_c);
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL wr5: got %h/%b/%b ok=%b%b required %h/%b/%b", got.rdata, got.err, got.tmo, ok_c, ok_r, exp.rdata, exp.err, exp.tmo);
        end
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, tmo: 1'b0});
        issue('{write: 1'b0, addr: 32'd5, wdata: 32'h0}, ok_c);
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL rd5: got %h/%b/%b ok=%b%b required %h/%b/%b", got.rdata, got.err, got.tmo, ok_c, ok_r, exp.rdata, exp.err, exp.tmo);
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL latency: rsp_valid %0d cycles after SETUP, required 3", lat);
        end
    endtask

    task automatic test_slverr();
        rsp_t got, exp;
        bit   ok_c, ok_r;
        int   lat;
        sb.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b0});
        issue('{write: 1'b0, addr: 32'd40, wdata: 32'h0}, ok_c);
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL slverr40: got %h/%b/%b ok=%b%b required %h/%b/%b", got.rdata, got.err, got.tmo, ok_c, ok_r, exp.rdata, exp.err, exp.tmo);
        end
    endtask

    task automatic test_timeout();
        rsp_t got, exp;
        bit   ok_c, ok_r;
        int   lat, seen;
        logic sel_at_rsp;
        stub = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
        issue('{write: 1'b0, addr: 32'd9, wdata: 32'h0}, ok_c);
        seen = 0;
        for (int n = 0; n < 60; n++) begin
            if (req.rsp_valid) break;
            if (apb.psel && apb.penable) seen++;
            @(posedge pclk); #1;
        end
        sel_at_rsp = apb.psel | apb.penable;
        total++;
        if (seen !== 16 || sel_at_rsp !== 1'b0) begin
            bad++;
            $display("FAIL tmo_access: access cycles=%0d sel_at_rsp=%b required 16/0", seen, sel_at_rsp);
        end
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL tmo_rsp: got %h/%b/%b ok=%b%b required %h/%b/%b", got.rdata, got.err, got.tmo, ok_c, ok_r, exp.rdata, exp.err, exp.tmo);
        end
        stub = 1'b0;
    endtask

    task automatic test_rsp_hold();
        rsp_t got, exp;
        bit   ok_c, ok_r;
        int   lat;
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, tmo: 1'b0});
        issue('{write: 1'b0, addr: 32'd5, wdata: 32'h0}, ok_c);
        for (int n = 0; n < 20 && !req.rsp_valid; n++) begin
            @(posedge pclk); #1;
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({req.rsp_valid, req.rsp_rdata, req.rsp_err, req.rsp_tmo, req.cmd_ready, apb.psel} !==
                {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_c%0d: vld=%b rdata=%h err=%b tmo=%b cmd_rdy=%b psel=%b required 1/deadbeef/0/0/0/0",
                         c, req.rsp_valid, req.rsp_rdata, req.rsp_err, req.rsp_tmo, req.cmd_ready, apb.psel);
            end
            @(posedge pclk); #1;
        end
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL hold_rsp: got %h/%b/%b ok=%b%b required %h/%b/%b", got.rdata, got.err, got.tmo, ok_c, ok_r, exp.rdata, exp.err, exp.tmo);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t got, exp;
        bit   ok_c, ok_r;
        int   lat;
        issue('{write: 1'b1, addr: 32'd7, wdata: 32'h11111111}, ok_c);
        for (int n = 0; n < 10 && !apb.penable; n++) begin
            @(posedge pclk); #1;
        end
        preset = 1'b1;
        #1;
        total++;
        if ({apb.psel, apb.penable} !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid_sel: psel/penable=%b required 00", {apb.psel, apb.penable});
        end
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        preset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge pclk); #1;
            total++;
            if ({req.rsp_valid, req.cmd_ready} !== 2'b01) begin
                bad++;
                $display("FAIL rst_mid_idle: rsp_valid/cmd_ready=%b required 01", {req.rsp_valid, req.cmd_ready});
            end
        end
        sb.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        sb.push_back('{rdata: 32'h12345678, err: 1'b0, tmo: 1'b0});
        issue('{write: 1'b1, addr: 32'd7, wdata: 32'h12345678}, ok_c);
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL rst_wr7: got %h/%b/%b required %h/%b/%b", got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
        end
        issue('{write: 1'b0, addr: 32'd7, wdata: 32'h0}, ok_c);
        collect(1'b0, got, ok_r, lat);
        exp = sb.pop_front();
        total++;
        if (!ok_c || !ok_r || got !== exp) begin
            bad++;
            $display("FAIL rst_rd7: got %h/%b/%b required %h/%b/%b", got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [32];
        rsp_t got, exp;
        bit   ok_c, ok_r;
        int   lat;
        req.rsp_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 32; i++) begin
                if (pass == 0) begin
                    data[i] = $urandom;
                    sb.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
                end else begin
                    sb.push_back('{rdata: data[i], err: 1'b0, tmo: 1'b0});
                end
                issue('{write: (pass == 0), addr: 32'(i), wdata: data[i]}, ok_c);
                collect(1'b1, got, ok_r, lat);
                exp = sb.pop_front();
                total++;
                if (!ok_c || !ok_r || got !== exp) begin
                    bad++;
                    $display("FAIL b2b_%s%0d: got %h/%b/%b required %h/%b/%b", (pass == 0) ? "wr" : "rd", i,
                             got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
                end
            end
        end
        req.rsp_ready = 1'b0;
    endtask

    initial begin
        req.cmd_valid = 1'b0;
        req.cmd_write = 1'b0;
        req.cmd_addr  = '0;
        req.cmd_wdata = '0;
        req.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_slverr();
        test_rsp_hold();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
